signature_checker: RTL and testbench

//  Receive end of the signature link: checks a serial bit stream against the

---
 rtl/sig_pkg.sv | 17 +
 rtl/sig_ref_model.sv | 41 ++++
 rtl/signature_checker.sv | 119 +++++++++++
 tb/tb_signature_checker.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sig_pkg.sv
// Shared definitions for the signature link: seed, FSM encoding and the bit function
// used by both generator and checker so their sequences cannot diverge.
package sig_pkg;

    localparam logic [7:0] SIG_SEED = 8'h55;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_DONE
    } state_t;

    function automatic logic sig_bit(input logic [7:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/sig_ref_model.sv
// Expected-sequence generator: 8-bit counter that reloads to SEED and steps once per
// accepted bit; exp_bit is the signature bit for the current counter value.
module sig_ref_model
    import sig_pkg::*;
#(
    parameter logic [7:0] SEED = SIG_SEED
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic step,
    output logic exp_bit
);

    logic [7:0] model_q;
    logic [7:0] model_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        model_d = model_q;
        if (load) begin
            model_d = SEED;
        end else if (step) begin
            model_d = model_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from values sampled at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q <= SEED;
        end else begin
            model_q <= model_d;
        end
    end

    assign exp_bit = sig_bit(model_q);

endmodule

// File: rtl/signature_checker.sv
// Receive end of the signature link: compares a serial stream against the reference
// sequence and reports pass/fail, a saturating error count and the first-mismatch index.
module signature_checker
    import sig_pkg::*;
#(
    parameter logic [7:0] SEED  = SIG_SEED,
    parameter int         LEN   = 16,
    parameter int         ERR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             din_valid,
    input  logic             din,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       first_err_idx
);

    localparam logic [7:0]       LAST_IDX = 8'(LEN - 1);
    localparam logic [7:0]       NO_ERR   = 8'hFF;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state_q, state_d;
    logic [7:0]       bit_idx_q, bit_idx_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       first_err_idx_q, first_err_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic exp_bit;
    logic accept;
    logic mismatch;

    // start takes priority, so a bit presented with start is discarded.
    assign accept   = (state_q == S_CHECK) && din_valid && !start;
    assign mismatch = accept && (din ^ exp_bit);

    sig_ref_model #(
        .SEED (SEED)
    ) u_ref_model (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (start),
        .step    (accept),
        .exp_bit (exp_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_CHECK;
        end else begin
            unique case (state_q)
                S_CHECK: if (accept && (bit_idx_q == LAST_IDX)) state_d = S_DONE;
                S_IDLE,
                S_DONE:  state_d = state_q;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Status flags are derived from the next state so they are registered alongside it.
    always_comb begin
        bit_idx_d       = bit_idx_q;
        err_cnt_d       = err_cnt_q;
        first_err_idx_d = first_err_idx_q;
        if (start) begin
            bit_idx_d       = 8'd0;
            err_cnt_d       = '0;
            first_err_idx_d = NO_ERR;
        end else if (accept) begin
            bit_idx_d = bit_idx_q + 8'd1;
            if (mismatch) begin
                if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
                if (first_err_idx_q == NO_ERR) first_err_idx_d = bit_idx_q;
            end
        end
        busy_d = (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx_q       <= 8'd0;
            err_cnt_q       <= '0;
            first_err_idx_q <= NO_ERR;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
        end else begin
            bit_idx_q       <= bit_idx_d;
            err_cnt_q       <= err_cnt_d;
            first_err_idx_q <= first_err_idx_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_signature_checker.sv
// Directed bench for signature_checker: default instance (seed 0x55, 16 bits) plus a
// short instance seeded 0xFC so the reference counter wraps through 0xFF -> 0x00.
module tb_signature_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, din_valid, din;
    logic       start2, din_valid2, din2;
    logic       busy, done, pass;
    logic [3:0] err_cnt;
    logic [7:0] first_err_idx;
    logic       busy2, done2, pass2;
    logic [3:0] err_cnt2;
    logic [7:0] first_err_idx2;

    int checks = 0;
    int errors = 0;

    // Parity of 0x55..0x64, bit i is the i-th expected signature bit.
    logic [15:0] clean_bits = 16'b1011_0011_0100_1100;
    // Parity of 0xFC..0x03 for the wrap instance.
    logic [7:0]  wrap_bits  = 8'b0110_0110;

    always #5 clk = ~clk;

    signature_checker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .din_valid     (din_valid),
        .din           (din),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx)
    );

    signature_checker #(
        .SEED (8'hFC),
        .LEN  (8)
    ) dut_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start2),
        .din_valid     (din_valid2),
        .din           (din2),
        .busy          (busy2),
        .done          (done2),
        .pass          (pass2),
        .err_cnt       (err_cnt2),
        .first_err_idx (first_err_idx2)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic b, input logic d, input logic p,
                              input logic [3:0] e, input logic [7:0] f);
        check({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
        check({tag, ".done"}, {7'd0, done}, {7'd0, d});
        check({tag, ".pass"}, {7'd0, pass}, {7'd0, p});
        check({tag, ".err_cnt"}, {4'd0, err_cnt}, {4'd0, e});
        check({tag, ".first_err_idx"}, first_err_idx, f);
    endtask

    task automatic expect_wrap(input string tag, input logic b, input logic d, input logic p,
                               input logic [3:0] e, input logic [7:0] f);
        check({tag, ".busy"}, {7'd0, busy2}, {7'd0, b});
        check({tag, ".done"}, {7'd0, done2}, {7'd0, d});
        check({tag, ".pass"}, {7'd0, pass2}, {7'd0, p});
        check({tag, ".err_cnt"}, {4'd0, err_cnt2}, {4'd0, e});
        check({tag, ".first_err_idx"}, first_err_idx2, f);
    endtask

    // All stimulus tasks are entered just after a falling edge and return on one.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic b);
        din_valid = 1'b1;
        din       = b;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic send2(input logic b);
        din_valid2 = 1'b1;
        din2       = b;
        @(negedge clk);
        din_valid2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0; din_valid = 1'b0; din = 1'b0;
        start2 = 1'b0; din_valid2 = 1'b0; din2 = 1'b0;
        repeat (2) @(negedge clk);
        expect_out("reset", 1'b0, 1'b0, 1'b0, 4'd0, 8'hFF);
        expect_wrap("reset_wrap", 1'b0, 1'b0, 1'b0, 4'd0, 8'hFF);
        rst_n = 1'b1;
        @(negedge clk);

        // din_valid in IDLE must not start anything.
        repeat (3) send(1'b1);
        expect_out("idle_ignore", 1'b0, 1'b0, 1'b0, 4'd0, 8'hFF);

        // Clean run.
        pulse_start();
        expect_out("clean_armed", 1'b1, 1'b0, 1'b0, 4'd0, 8'hFF);
        for (int i = 0; i < 15; i++) send(clean_bits[i]);
        expect_out("clean_bit14", 1'b1, 1'b0, 1'b0, 4'd0, 8'hFF);
        send(clean_bits[15]);
        expect_out("clean_done", 1'b0, 1'b1, 1'b1, 4'd0, 8'hFF);

        // Single flipped bit at index 2.
        pulse_start();
        expect_out("flip_armed", 1'b1, 1'b0, 1'b0, 4'd0, 8'hFF);
        for (int i = 0; i < 3; i++) send(clean_bits[i] ^ (i == 2));
        expect_out("flip_after2", 1'b1, 1'b0, 1'b0, 4'd1, 8'd2);
        for (int i = 3; i < 16; i++) send(clean_bits[i]);
        expect_out("flip_done", 1'b0, 1'b1, 1'b0, 4'd1, 8'd2);

        // Every bit inverted: count saturates at 15.
        pulse_start();
        for (int i = 0; i < 15; i++) send(~clean_bits[i]);
        expect_out("sat_at15", 1'b1, 1'b0, 1'b0, 4'd15, 8'd0);
        send(~clean_bits[15]);
        expect_out("sat_done", 1'b0, 1'b1, 1'b0, 4'd15, 8'd0);

        // din_valid in DONE is ignored.
        repeat (3) send(1'b1);
        expect_out("done_ignore", 1'b0, 1'b1, 1'b0, 4'd15, 8'd0);

        // Gapped clean run: model must hold through idle cycles.
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            if (i % 3 == 1) begin
                @(negedge clk);
                check("gap_busy", {7'd0, busy}, 8'd1);
            end
            send(clean_bits[i]);
        end
        expect_out("gap_done", 1'b0, 1'b1, 1'b1, 4'd0, 8'hFF);
        repeat (2) send(1'b0);
        expect_out("gap_done_ignore", 1'b0, 1'b1, 1'b1, 4'd0, 8'hFF);

        // Restart mid-run; start with a wrong bit in the same cycle must discard it.
        pulse_start();
        for (int i = 0; i < 6; i++) send(clean_bits[i] ^ (i == 3));
        expect_out("restart_pre", 1'b1, 1'b0, 1'b0, 4'd1, 8'd3);
        start = 1'b1; din_valid = 1'b1; din = ~clean_bits[0];
        @(negedge clk);
        start = 1'b0; din_valid = 1'b0;
        expect_out("restart_cleared", 1'b1, 1'b0, 1'b0, 4'd0, 8'hFF);
        for (int i = 0; i < 15; i++) send(clean_bits[i]);
        expect_out("restart_bit14", 1'b1, 1'b0, 1'b0, 4'd0, 8'hFF);
        send(clean_bits[15]);
        expect_out("restart_done", 1'b0, 1'b1, 1'b1, 4'd0, 8'hFF);

        // Asynchronous reset part-way through a run with an error logged.
        pulse_start();
        for (int i = 0; i < 7; i++) send(clean_bits[i] ^ (i == 1));
        expect_out("midrun_pre", 1'b1, 1'b0, 1'b0, 4'd1, 8'd1);
        #2 rst_n = 1'b0;
        #1 expect_out("midrun_reset", 1'b0, 1'b0, 1'b0, 4'd0, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        for (int i = 0; i < 16; i++) send(clean_bits[i]);
        expect_out("post_reset_done", 1'b0, 1'b1, 1'b1, 4'd0, 8'hFF);

        // Wrap instance: counter runs 0xFC..0x03.
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 8; i++) send2(wrap_bits[i]);
        expect_wrap("wrap_clean", 1'b0, 1'b1, 1'b1, 4'd0, 8'hFF);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 8; i++) send2(wrap_bits[i] ^ (i == 4));
        expect_wrap("wrap_flip4", 1'b0, 1'b1, 1'b0, 4'd1, 8'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
